// File: rtl/ecc_secded_dec.sv
// Extended-Hamming SECDED decoder: corrects single-bit errors, flags double-bit errors,
// with an optional 0/1/2-stage output pipeline.
module ecc_secded_dec #(
  parameter int K       = 72,
  parameter int P0_LSB  = 0,
  parameter int LATENCY = 0,
  localparam int M0 = $clog2(K + 1),
  localparam int M1 = $clog2(K + 1 + M0),
  localparam int M  = $clog2(K + 1 + M1),
  localparam int N  = M + K
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clkena_i,
  input  logic [N:0]   d_i,
  output logic [K-1:0] q_o,
  output logic [M-1:0] syndrome_o,
  output logic         sb_err_o,
  output logic         db_err_o,
  output logic         sb_fix_o
);

  // Word bit index of Hamming position i is i - OFF (p0 sits at bit 0 or bit N).
  localparam int OFF = (P0_LSB != 0) ? 0 : 1;

  function automatic int info_pos(input int idx);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  logic [M-1:0] syn_c;
  logic         perr_c;
  logic [K-1:0] raw_c;

  always_comb begin
    syn_c = '0;
    for (int j = 0; j < M; j++) begin
      for (int i = 1; i <= N; i++) begin
        if (((i >> j) & 1) != 0) syn_c[j] = syn_c[j] ^ d_i[i-OFF];
      end
    end
  end

  assign perr_c = ^d_i;

  // Back-end inputs: either straight from the front end or from stage-1 registers.
  logic [K-1:0] info_be;
  logic [M-1:0] syn_be;
  logic         perr_be;
  logic         in_range;

  logic [K-1:0] q_d;
  logic         sb_d, db_d, fix_d;

  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_info
      localparam int P = info_pos(gi);
      assign raw_c[gi] = d_i[P-OFF];
      assign q_d[gi]   = info_be[gi] ^ (in_range && (syn_be == M'(P)));
    end
  endgenerate

  assign in_range = perr_be && (syn_be != '0) && (int'(syn_be) <= N);
  assign sb_d     = perr_be && ((syn_be == '0) || in_range);
  assign db_d     = (!perr_be && (syn_be != '0)) || (perr_be && (int'(syn_be) > N));
  // A power-of-two syndrome points at a parity bit, so no information bit changes.
  assign fix_d    = in_range && ((syn_be & (syn_be - M'(1))) != '0);

  generate
    if (LATENCY == 2) begin : g_stage1
      logic [K-1:0] info_q;
      logic [M-1:0] syn_q;
      logic         perr_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          info_q <= '0;
          syn_q  <= '0;
          perr_q <= 1'b0;
        end else if (clkena_i) begin
          info_q <= raw_c;
          syn_q  <= syn_c;
          perr_q <= perr_c;
        end
      end

      assign info_be = info_q;
      assign syn_be  = syn_q;
      assign perr_be = perr_q;
    end else begin : g_nostage1
      assign info_be = raw_c;
      assign syn_be  = syn_c;
      assign perr_be = perr_c;
    end

    if (LATENCY == 0) begin : g_comb_out
      logic unused_ctrl;
      assign unused_ctrl = clk_i ^ rst_ni ^ clkena_i;
      assign q_o         = q_d;
      assign syndrome_o  = syn_be;
      assign sb_err_o    = sb_d;
      assign db_err_o    = db_d;
      assign sb_fix_o    = fix_d;
    end else begin : g_reg_out
      logic [K-1:0] q_q;
      logic [M-1:0] syn_out_q;
      logic         sb_q, db_q, fix_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          q_q       <= '0;
          syn_out_q <= '0;
          sb_q      <= 1'b0;
          db_q      <= 1'b0;
          fix_q     <= 1'b0;
        end else if (clkena_i) begin
          q_q       <= q_d;
          syn_out_q <= syn_be;
          sb_q      <= sb_d;
          db_q      <= db_d;
          fix_q     <= fix_d;
        end
      end

      assign q_o        = q_q;
      assign syndrome_o = syn_out_q;
      assign sb_err_o   = sb_q;
      assign db_err_o   = db_q;
      assign sb_fix_o   = fix_q;
    end
  endgenerate

endmodule

// File: tb/tb_ecc_secded_dec.sv
// Directed bench for ecc_secded_dec: K=4 reference table plus K=72 streams across
// all latency / p0-placement combinations, clock-enable hold and reset sequences.
module tb_ecc_secded_dec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic clkena;

  // K=4 reference decoder (P0_LSB=1, combinational)
  logic [7:0] d4;
  logic [3:0] q4;
  logic [2:0] syn4;
  logic       sb4, db4, fix4;

  ecc_secded_dec #(.K(4), .P0_LSB(1), .LATENCY(0)) u_k4 (
    .clk_i(clk), .rst_ni(rst_n), .clkena_i(clkena), .d_i(d4),
    .q_o(q4), .syndrome_o(syn4), .sb_err_o(sb4), .db_err_o(db4), .sb_fix_o(fix4)
  );

  // K=72 decoders: instance i has LATENCY i/2 and P0_LSB i%2
  logic [79:0] d72 [2];
  logic [71:0] q72 [6];
  logic [6:0]  syn72 [6];
  logic        sb72 [6];
  logic        db72 [6];
  logic        fix72 [6];

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_dut
      ecc_secded_dec #(.K(72), .P0_LSB(gi % 2), .LATENCY(gi / 2)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .clkena_i(clkena), .d_i(d72[gi%2]),
        .q_o(q72[gi]), .syndrome_o(syn72[gi]), .sb_err_o(sb72[gi]),
        .db_err_o(db72[gi]), .sb_fix_o(fix72[gi])
      );
    end
  endgenerate

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] q;
    logic [2:0] syn;
    logic       sb;
    logic       db;
    logic       fix;
  } vec4_t;

  typedef struct packed {
    logic [71:0] q;
    logic [6:0]  syn;
    logic        sb;
    logic        db;
    logic        fix;
  } res72_t;

  int     tests = 0;
  int     fails = 0;
  int     info_of_pos [80];
  res72_t hist [0:4095];
  int     nvec = 0;
  res72_t zero_r;

  function automatic logic [71:0] rand72();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[71:0];
  endfunction

  function automatic logic [79:0] encode(input logic [71:0] data, input logic [79:0] flips,
                                         input int p0lsb);
    logic [79:0] pos;
    logic        b;
    int          idx;
    pos = '0;
    idx = 0;
    for (int p = 1; p < 80; p++) begin
      if ((p & (p - 1)) != 0) begin
        pos[p] = data[idx];
        idx++;
      end
    end
    for (int j = 0; j < 7; j++) begin
      b = 1'b0;
      for (int p = 1; p < 80; p++)
        if ((((p >> j) & 1) != 0) && (p != (1 << j))) b = b ^ pos[p];
      pos[1<<j] = b;
    end
    pos[0] = ^pos[79:1];
    pos = pos ^ flips;
    if (p0lsb != 0) return pos;
    return {pos[0], pos[79:1]};
  endfunction

  // Expected decoder response for codeword(data) with the given position flips
  function automatic res72_t model(input logic [71:0] data, input logic [79:0] flips);
    res72_t      r;
    logic        perr;
    logic        corr;
    int          s;
    logic [79:0] eff;
    logic [71:0] q;
    perr = ^flips;
    s = 0;
    for (int p = 0; p < 80; p++) if (flips[p]) s = s ^ p;
    corr = perr && (s >= 1) && (s <= 79);
    eff = flips;
    if (corr) eff[s] = ~eff[s];
    q = data;
    for (int p = 1; p < 80; p++)
      if (eff[p] && (info_of_pos[p] >= 0)) q[info_of_pos[p]] = ~q[info_of_pos[p]];
    r.q   = q;
    r.syn = s[6:0];
    r.sb  = perr && ((s == 0) || corr);
    r.db  = (!perr && (s != 0)) || (perr && (s > 79));
    r.fix = corr && (info_of_pos[s] >= 0);
    return r;
  endfunction

  task automatic check72(input int inst, input res72_t exp, input string tag);
    res72_t act;
    act = {q72[inst], syn72[inst], sb72[inst], db72[inst], fix72[inst]};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d (lat %0d, p0lsb %0d): got q=%h syn=%0d sb=%b db=%b fix=%b, want q=%h syn=%0d sb=%b db=%b fix=%b",
               tag, inst, inst / 2, inst % 2, act.q, act.syn, act.sb, act.db, act.fix,
               exp.q, exp.syn, exp.sb, exp.db, exp.fix);
    end
  endtask

  task automatic drive72(input logic [71:0] data, input logic [79:0] flips);
    d72[0] = encode(data, flips, 0);
    d72[1] = encode(data, flips, 1);
  endtask

  task automatic stream_vec(input logic [71:0] data, input logic [79:0] flips, input string tag);
    @(posedge clk);
    #1;
    drive72(data, flips);
    hist[nvec] = model(data, flips);
    @(negedge clk);
    for (int i = 0; i < 6; i++)
      if (nvec >= i / 2) check72(i, hist[nvec-i/2], tag);
    $display("[TB] %s vec %0d flips=%0d syn=%0d sb=%b db=%b fix=%b", tag, nvec,
             $countones(flips), hist[nvec].syn, hist[nvec].sb, hist[nvec].db, hist[nvec].fix);
    nvec++;
  endtask

  vec4_t       tab [11];
  logic [79:0] f;
  logic [71:0] da, db_v, dc;
  res72_t      exp_a, exp_b, exp_c;

  initial begin
    zero_r = '0;
    begin
      int k;
      k = 0;
      for (int p = 0; p < 80; p++) begin
        if ((p == 0) || ((p & (p - 1)) == 0)) info_of_pos[p] = -1;
        else begin
          info_of_pos[p] = k;
          k++;
        end
      end
    end

    rst_n  = 1'b0;
    clkena = 1'b1;
    d4     = 8'h00;
    drive72(72'h0, 80'h0);
    #1;
    for (int i = 2; i < 6; i++) check72(i, zero_r, "reset_initial");

    //              d       q     syn  sb    db    fix
    tab[0]  = '{8'hAA, 4'hB, 3'd0, 1'b0, 1'b0, 1'b0};
    tab[1]  = '{8'h8A, 4'hB, 3'd5, 1'b1, 1'b0, 1'b1};
    tab[2]  = '{8'hBA, 4'hB, 3'd4, 1'b1, 1'b0, 1'b0};
    tab[3]  = '{8'hAB, 4'hB, 3'd0, 1'b1, 1'b0, 1'b0};
    tab[4]  = '{8'hAC, 4'hB, 3'd3, 1'b0, 1'b1, 1'b0};
    tab[5]  = '{8'h2A, 4'hB, 3'd7, 1'b1, 1'b0, 1'b1};
    tab[6]  = '{8'hA8, 4'hB, 3'd1, 1'b1, 1'b0, 1'b0};
    tab[7]  = '{8'h82, 4'h8, 3'd6, 1'b0, 1'b1, 1'b0};
    tab[8]  = '{8'hFF, 4'hF, 3'd0, 1'b0, 1'b0, 1'b0};
    tab[9]  = '{8'h00, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0};
    tab[10] = '{8'hA2, 4'hB, 3'd3, 1'b1, 1'b0, 1'b1};

    for (int i = 0; i < 11; i++) begin
      d4 = tab[i].d;
      #1;
      tests++;
      if ({q4, syn4, sb4, db4, fix4} !== {tab[i].q, tab[i].syn, tab[i].sb, tab[i].db, tab[i].fix}) begin
        fails++;
        $display("FAIL k4_vec%0d d=%h: got q=%h syn=%0d sb=%b db=%b fix=%b, want q=%h syn=%0d sb=%b db=%b fix=%b",
                 i, tab[i].d, q4, syn4, sb4, db4, fix4,
                 tab[i].q, tab[i].syn, tab[i].sb, tab[i].db, tab[i].fix);
      end
      $display("[TB] k4 vec %0d d=%h q=%h syn=%0d", i, tab[i].d, q4, syn4);
    end

    @(negedge clk);
    rst_n = 1'b1;

    stream_vec(72'h0, 80'h0, "clean");
    stream_vec({72{1'b1}}, 80'h0, "clean");
    for (int i = 0; i < 6; i++) stream_vec(rand72(), 80'h0, "clean");
    for (int p = 0; p < 80; p++) begin
      f = '0;
      f[p] = 1'b1;
      stream_vec(rand72(), f, "single");
    end
    for (int p1 = 0; p1 < 79; p1++) begin
      for (int p2 = p1 + 1; p2 < 80; p2++) begin
        f = '0;
        f[p1] = 1'b1;
        f[p2] = 1'b1;
        stream_vec(rand72(), f, "double");
      end
    end
    // odd-weight flips whose syndrome exceeds n (81, 127) or lands on a position (79)
    f = '0; f[1] = 1'b1; f[16] = 1'b1; f[64] = 1'b1;
    stream_vec(rand72(), f, "triple");
    f = '0; f[31] = 1'b1; f[32] = 1'b1; f[64] = 1'b1;
    stream_vec(rand72(), f, "triple");
    f = '0; f[7] = 1'b1; f[8] = 1'b1; f[64] = 1'b1;
    stream_vec(rand72(), f, "triple");

    // clock-enable hold
    da = rand72();
    db_v = rand72();
    f = '0; f[37] = 1'b1;
    exp_a = model(da, f);
    exp_b = model(db_v, 80'h0);
    @(posedge clk);
    #1;
    drive72(da, f);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 6; i++) check72(i, exp_a, "hold_load");
    clkena = 1'b0;
    drive72(db_v, 80'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) check72(i, exp_b, "hold_comb");
    for (int i = 2; i < 6; i++) check72(i, exp_a, "hold_freeze");
    $display("[TB] hold: clkena low for 3 cycles");
    clkena = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 2; i < 4; i++) check72(i, exp_b, "hold_resume1");
    for (int i = 4; i < 6; i++) check72(i, exp_a, "hold_resume1");
    @(posedge clk);
    @(negedge clk);
    for (int i = 4; i < 6; i++) check72(i, exp_b, "hold_resume2");
    $display("[TB] hold: resumed");

    // asynchronous reset mid-stream
    dc = rand72();
    f = '0; f[3] = 1'b1; f[70] = 1'b1;
    exp_c = model(dc, f);
    drive72(dc, f);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 6; i++) check72(i, exp_c, "rst_preload");
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) check72(i, exp_c, "rst_comb");
    for (int i = 2; i < 6; i++) check72(i, zero_r, "rst_async");
    @(posedge clk);
    @(negedge clk);
    for (int i = 2; i < 6; i++) check72(i, zero_r, "rst_held");
    rst_n = 1'b1;
    #1;
    for (int i = 2; i < 6; i++) check72(i, zero_r, "rst_release");
    @(posedge clk);
    @(negedge clk);
    for (int i = 2; i < 4; i++) check72(i, exp_c, "rst_first_edge");
    for (int i = 4; i < 6; i++) check72(i, zero_r, "rst_first_edge");
    @(posedge clk);
    @(negedge clk);
    for (int i = 4; i < 6; i++) check72(i, exp_c, "rst_second_edge");
    $display("[TB] reset sequence done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ecc_secded_dec.md
# ecc_secded_dec

Parameterised Hamming SECDED decoder with a selectable output pipeline. It takes an (n+1)-bit extended-Hamming code word from the storage or channel side of a link, corrects any single-bit error, and detects double-bit errors. It returns the K-bit information vector, the syndrome and three status flags to the consumer. It is the receive-side partner of the team's ECC encoder and uses the same code-word layout.

## Interface
- K, 72: information bits. m = smallest integer with 2^m ≥ m+K+1; n = m+K; code word width n+1 (K=72 → m=7, n=79, 80-bit word).
- P0_LSB, 0: 1 places overall parity p0 at code-word bit 0; 0 places it at bit n.
- LATENCY, 0: output pipeline depth. Legal values are 0, 1 and 2.

- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous, active-low reset.
- clkena_i  input  1  clock enable for all pipeline registers.
- d_i  input  n+1  received code word.
- q_o  output  K  corrected information bits.
- syndrome_o  output  m  Hamming syndrome.
- sb_err_o  output  1  single-bit error detected.
- db_err_o  output  1  double-bit (uncorrectable) error detected.
- sb_fix_o  output  1  an information bit was corrected.

## Operation
- Hamming positions run 1..n. Parity bit j sits at position 2^j (j = 0..m-1). Information bits d[0..K-1] fill the remaining positions in ascending order.
- Mapping of positions to code-word bits:
  - P0_LSB=1: bit 0 = p0; bit i = position i.
  - P0_LSB=0: bit n = p0; bit i-1 = position i.
- p0 is the XOR of all other n bits, giving even overall parity.
- Syndrome bit j is the XOR of received positions i (1..n) whose index has bit j set, including the parity bit at position 2^j.
- perr = XOR of all n+1 received bits.
- Classification:
  - perr=1, syndrome=0: p0 itself flipped. sb_err=1, db_err=0, no correction, sb_fix=0.
  - perr=1, 1 ≤ syndrome ≤ n: invert that position. sb_err=1, db_err=0. sb_fix=1 only if the position holds an information bit.
  - perr=1, syndrome > n: uncorrectable. sb_err=0, db_err=1, sb_fix=0.
  - perr=0, syndrome≠0: sb_err=0, db_err=1, no correction. q_o carries the raw received information bits.
  - perr=0, syndrome=0: clean word. All flags 0.
- Flags are mutually exclusive. sb_fix implies sb_err.
- Three or more flipped bits may be misclassified. Behaviour follows the rules above with no extra detection.

## Timing
- LATENCY=0: fully combinational, d_i → all outputs in the same cycle. clk_i, rst_ni and clkena_i are unused.
- LATENCY=1: syndrome, perr and corrected data are computed combinationally. All outputs are registered on the clk_i rising edge when clkena_i=1, giving 1-cycle latency.
- LATENCY=2: d_i, syndrome and perr are registered in stage 1. Correction and flags are computed from the stage-1 values and registered in stage 2, giving 2-cycle latency.
- clkena_i=0 freezes every pipeline stage; outputs hold their values.
- rst_ni low asynchronously clears all pipeline registers. q_o, syndrome_o and all flags read 0 while in reset and until the first enabled edge after release.
- Reset asserted mid-stream discards in-flight words. There is no other state.
- Back-to-back words are accepted every enabled cycle; there is no handshake.

## Test plan
Reference vector: K=4 (m=3, n=7, 8-bit word), P0_LSB=1, d=4'hB encodes to 8'hAA.

- d_i=8'hAA -> q_o=4'hB, syndrome 0, all flags 0.
- 8'hAA with bit 5 flipped (8'h8A) -> q_o=4'hB, syndrome 5, sb_err=1, sb_fix=1, db_err=0.
- 8'hAA with bit 4 flipped (8'hBA, parity position) -> q_o=4'hB, syndrome 4, sb_err=1, sb_fix=0.
- 8'hAA with bit 0 flipped (8'hAB, p0) -> q_o=4'hB, syndrome 0, sb_err=1, sb_fix=0, db_err=0.
- 8'hAA with bits 1 and 2 flipped (8'hAC) -> syndrome 3, db_err=1, sb_err=0, sb_fix=0, q_o=4'hB (raw).
- K=72, P0_LSB=0 and 1, LATENCY 0/1/2, paired with the encoder:
  - Random data with 0, 1 (every position 0..n) and 2 (every distinct pair) flips.
  - Required: exact data and flag match after LATENCY cycles.
  - Toggle clkena_i low and confirm outputs hold.
  - Assert rst_ni mid-stream and confirm outputs read 0.
